// File: rtl/rr_arb_pkg.sv
// rtl/rr_arb_pkg.sv - shared constants, state type and helpers for the 8-way round-robin arbiter
//   NUM_REQ : number of requesters
//   IDX_W   : width of an encoded requester index
//   state_t : arbiter FSM state (IDLE, GRANT)
//   onehot  : index -> one-hot grant vector
package rr_arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_prio_enc_8.sv
// rtl/rr_prio_enc_8.sv - masked priority encoder picking the round-robin winner
//   req       in  [7:0] request vector
//   ptr       in  [2:0] round-robin start position
//   win_idx   out [2:0] lowest requesting index at or above ptr, else lowest overall
//   win_valid out       any request present
module rr_prio_enc_8
  import rr_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   win_idx,
  output logic               win_valid
);

  logic [NUM_REQ-1:0] mask;
  logic [NUM_REQ-1:0] masked_req;
  logic [IDX_W-1:0]   masked_idx;
  logic               masked_valid;
  logic [IDX_W-1:0]   plain_idx;

  always_comb begin
    // Keep only requesters at or above ptr; bits below ptr are cleared.
    mask       = ~((NUM_REQ'(1) << ptr) - NUM_REQ'(1));
    masked_req = req & mask;

    masked_idx   = '0;
    masked_valid = 1'b0;
    plain_idx    = '0;
    // Scan downward so the lowest set bit is the last one written.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (masked_req[i]) begin
        masked_idx   = IDX_W'(i);
        masked_valid = 1'b1;
      end
      if (req[i]) begin
        plain_idx = IDX_W'(i);
      end
    end

    // Nothing at or above ptr: wrap around to the lowest requester overall.
    win_idx   = masked_valid ? masked_idx : plain_idx;
    win_valid = |req;
  end

endmodule

// File: rtl/rr_arbiter_8.sv
// rtl/rr_arbiter_8.sv - 8-requester round-robin arbiter with hold limit and enable
//   clk       in        rising-edge clock
//   rst_n     in        asynchronous active-low reset
//   en        in        arbitration enable; low releases any grant and blocks new ones
//   req       in  [7:0] request vector, held for the whole transaction
//   gnt       out [7:0] registered one-hot grant
//   gnt_idx   out [2:0] encoded index of the grant, 0 when idle
//   gnt_valid out       any grant active
//   timeout   out       one-cycle pulse after a release forced by the hold limit
module rr_arbiter_8
  import rr_arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_ONE   = HOLD_W'(1);

  state_t             state, state_d;
  logic [IDX_W-1:0]   ptr, ptr_d;
  logic [HOLD_W-1:0]  hold, hold_d;
  logic [NUM_REQ-1:0] gnt_d;
  logic [IDX_W-1:0]   gnt_idx_d;
  logic               gnt_valid_d;
  logic               timeout_d;

  logic               held_req;
  logic               hold_limit;
  logic               release_grant;
  logic [IDX_W-1:0]   arb_ptr;
  logic [IDX_W-1:0]   win_idx;
  logic               win_valid;

  // Release decision for the current holder.
  always_comb begin
    held_req      = req[gnt_idx];
    hold_limit    = (MAX_HOLD != 0) && (hold == HOLD_LIMIT);
    release_grant = (state == GRANT) && (!held_req || !en || hold_limit);
    // On release, re-arbitrate this cycle from the slot after the holder so
    // the handover costs no idle cycle. Index arithmetic wraps 7 -> 0.
    arb_ptr       = release_grant ? (gnt_idx + IDX_W'(1)) : ptr;
  end

  rr_prio_enc_8 u_prio_enc (
    .req       (req),
    .ptr       (arb_ptr),
    .win_idx   (win_idx),
    .win_valid (win_valid)
  );

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    hold_d      = hold;
    gnt_d       = gnt;
    gnt_idx_d   = gnt_idx;
    gnt_valid_d = gnt_valid;
    timeout_d   = 1'b0;

    unique case (state)
      IDLE: begin
        if (en && win_valid) begin
          state_d     = GRANT;
          gnt_d       = onehot(win_idx);
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          hold_d      = HOLD_ONE;
        end
      end

      GRANT: begin
        if (!release_grant) begin
          // Saturate so an unlimited hold (MAX_HOLD = 0) never wraps.
          if (hold != '1) begin
            hold_d = hold + HOLD_ONE;
          end
        end else begin
          ptr_d     = arb_ptr;
          // Pulse only when the hold limit alone forced the release.
          timeout_d = hold_limit && held_req && en;
          if (en && win_valid) begin
            gnt_d       = onehot(win_idx);
            gnt_idx_d   = win_idx;
            gnt_valid_d = 1'b1;
            hold_d      = HOLD_ONE;
          end else begin
            state_d     = IDLE;
            gnt_d       = '0;
            gnt_idx_d   = '0;
            gnt_valid_d = 1'b0;
            hold_d      = '0;
          end
        end
      end

      default: begin
        state_d     = IDLE;
        gnt_d       = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        hold_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold      <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      hold      <= hold_d;
      gnt       <= gnt_d;
      gnt_idx   <= gnt_idx_d;
      gnt_valid <= gnt_valid_d;
      timeout   <= timeout_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(gnt));
  a_gnt_idx     : assert property (@(posedge clk) disable iff (!rst_n)
                                   gnt_valid |-> (gnt == onehot(gnt_idx)));
  a_gnt_valid   : assert property (@(posedge clk) disable iff (!rst_n) gnt_valid == (|gnt));

endmodule

// File: tb/tb_rr_arbiter_8.sv
// tb/tb_rr_arbiter_8.sv - directed self-checking bench for rr_arbiter_8
module tb_rr_arbiter_8;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int n_checks;
  int n_fail;

  wire [12:0] obs = {gnt, gnt_idx, gnt_valid, timeout};

  rr_arbiter_8 #(.MAX_HOLD(16), .HOLD_W(5)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .req       (req),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected {gnt, gnt_idx, gnt_valid, timeout}.
  function automatic logic [12:0] ev(input bit v, input int idx, input bit to);
    logic [2:0] ix;
    logic [7:0] g;
    ix = v ? 3'(idx) : 3'd0;
    g  = v ? (8'd1 << ix) : 8'd0;
    return {g, ix, v, to};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    en    = 1'b1;
    req   = 8'h00;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [12:0] exp;
    do_reset();
    exp = ev(0, 0, 0);
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: got %h expected %h", c, obs, exp);
      end
    end
  endtask

  task automatic test_single();
    logic [12:0] exp;
    do_reset();
    req = 8'h01;
    for (int c = 1; c <= 5; c++) begin
      if (c == 4) req = 8'h00;
      step();
      exp = (c <= 3) ? ev(1, 0, 0) : ev(0, 0, 0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL single c%0d: got %h expected %h", c, obs, exp);
      end
      if (c == 3) req = 8'h00;
    end
    // ptr now 1: with requesters 0 and 1, requester 1 wins.
    req = 8'h03;
    step();
    exp = ev(1, 1, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_ptr1: got %h expected %h", obs, exp);
    end
    req = 8'h00;
    step();
    exp = ev(0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_clear: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_rotation();
    logic [12:0] exp;
    int prev;
    do_reset();
    req  = 8'hFF;
    prev = -1;
    for (int g = 0; g <= 8; g++) begin
      exp = ev(1, g % 8, 0);
      step();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rotation g%0d first: got %h expected %h", g, obs, exp);
      end
      if (prev >= 0) req[prev] = 1'b1;
      step();
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rotation g%0d second: got %h expected %h", g, obs, exp);
      end
      req[g % 8] = 1'b0;
      prev       = g % 8;
    end
    req = 8'h00;
    step();
    step();
  endtask

  task automatic test_wrap();
    logic [12:0] exp;
    do_reset();
    // Grant 5 and release it so ptr becomes 6.
    req = 8'h20;
    step();
    req = 8'h00;
    step();
    req = 8'h41;
    step();
    exp = ev(1, 6, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_first: got %h expected %h", obs, exp);
    end
    req = 8'h01;
    step();
    exp = ev(1, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_second: got %h expected %h", obs, exp);
    end
    req = 8'h00;
    step();
    exp = ev(0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL wrap_clear: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_timeout();
    logic [12:0] exp;
    do_reset();
    req = 8'h08;
    for (int c = 1; c <= 40; c++) begin
      step();
      exp = ev(1, 3, (c == 17) || (c == 33));
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL timeout c%0d: got %h expected %h", c, obs, exp);
      end
    end
    req = 8'h00;
    step();
    exp = ev(0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL timeout_clear: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_enable();
    logic [12:0] exp;
    do_reset();
    en  = 1'b0;
    req = 8'h24;
    for (int c = 0; c < 3; c++) begin
      step();
      exp = ev(0, 0, 0);
      n_checks++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL en_block c%0d: got %h expected %h", c, obs, exp);
      end
    end
    en = 1'b1;
    step();
    exp = ev(1, 2, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL en_grant2: got %h expected %h", obs, exp);
    end
    en = 1'b0;
    step();
    exp = ev(0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL en_drop: got %h expected %h", obs, exp);
    end
    en = 1'b1;
    step();
    exp = ev(1, 5, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL en_grant5: got %h expected %h", obs, exp);
    end
    req = 8'h00;
    step();
  endtask

  task automatic test_async_reset();
    logic [12:0] exp;
    do_reset();
    // Grant 4, release (ptr 5), then grant 6 from requesters 4 and 6.
    req = 8'h10;
    step();
    req = 8'h00;
    step();
    req = 8'h50;
    step();
    exp = ev(1, 6, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_pre: got %h expected %h", obs, exp);
    end
    #3;
    rst_n = 1'b0;
    #1;
    exp = ev(0, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_clear: got %h expected %h", obs, exp);
    end
    req = 8'h41;
    step();
    rst_n = 1'b1;
    step();
    // ptr back at 0: requester 0 beats 6.
    exp = ev(1, 0, 0);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL areset_ptr0: got %h expected %h", obs, exp);
    end
    req = 8'h00;
    step();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    en       = 1'b0;
    req      = 8'h00;
    #1;
    n_checks++;
    if (obs !== ev(0, 0, 0)) begin
      n_fail++;
      $display("FAIL reset_async_init: got %h expected %h", obs, ev(0, 0, 0));
    end
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_timeout();
    test_enable();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_8.md
Name: rr_arbiter_8

Overview:
- Round-robin arbiter that shares one downstream resource among 8 requesters.
- Produces a registered one-hot grant and its 3-bit encoded index for the 8-to-3 encoded select path.
- Sits in front of a shared resource, such as a bus port or output mux, whose select is the encoded index.
- Adds per-grant hold tracking, forced release on a hold timeout, and a global enable.

Parameters:
- MAX_HOLD, 16, maximum consecutive cycles one grant is held before forced release; 0 = unlimited.
- HOLD_W, 5, width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset; asynchronous, active-low.
- en  input  1  arbitration enable; low = no new grants, and any current grant is released.
- req  input  8  request vector; req[i] high = requester i wants the resource; held high for the whole transaction.
- gnt  output  8  registered one-hot grant; all-zero when nothing is granted.
- gnt_idx  output  3  binary index of the set gnt bit; 3'b000 when gnt_valid is low.
- gnt_valid  output  1  high while any grant is active (equals |gnt).
- timeout  output  1  one-cycle pulse in the cycle after a forced release caused by MAX_HOLD.

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE, gnt=8'h00, gnt_idx=3'b000, gnt_valid=0, timeout=0.
  - Round-robin pointer ptr=3'd0; hold counter=0.
- Winner selection (combinational):
  - The winner is the lowest index i with i>=ptr and req[i]=1.
  - If there is none, it is the lowest index overall with req[i]=1 (wrap search).
  - No request means no winner.
- States: IDLE, GRANT.
- IDLE:
  - If en=1 and a winner exists, at the next edge: gnt=onehot(winner), gnt_idx=winner, gnt_valid=1, hold counter=1, go to GRANT.
  - Latency from req rising to gnt is 1 cycle.
- GRANT, release conditions (any of):
  - req[gnt_idx]=0.
  - en=0.
  - MAX_HOLD!=0 and hold counter==MAX_HOLD.
- GRANT, no release: grant holds and the hold counter increments (saturating at all-ones when MAX_HOLD=0).
- GRANT, on release:
  - ptr=gnt_idx+1, mod 8 (7 wraps to 0).
  - Re-arbitration in the same cycle uses the updated ptr.
  - If en=1 and a winner exists, the next edge loads the new grant directly with no idle gap, hold counter=1, and the state stays GRANT.
  - Otherwise, the next edge clears gnt, gnt_idx and gnt_valid, and the state goes to IDLE.
- Timeout:
  - When a release is caused only by the hold limit (req still high and en=1), timeout=1 for exactly the following cycle.
  - If that requester is the sole requester, it is re-granted immediately after the timeout, with the counter restarted at 1.
- Simultaneous release and new requests: the new request set is sampled in the release cycle, so a request rising in that cycle can win.
- en:
  - en=0 in IDLE blocks grants; ptr is unchanged.
  - en falling in GRANT releases at the next edge, ptr advances, and no timeout pulse is generated.
- Reset mid-grant: outputs clear immediately (asynchronous) and ptr returns to 0.
- Invariants: gnt is always zero or one-hot; gnt_idx always matches gnt; no requester is starved longer than 7 grants.

Decomposition:
- Package rr_arb_pkg holds:
  - NUM_REQ=8 and IDX_W=3.
  - The state typedef {IDLE, GRANT}.
  - Function onehot(idx).
- One sub-module: rr_prio_enc_8.
  - Combinational masked priority encoder.
  - Inputs: req[7:0], ptr[2:0].
  - Outputs: win_idx[2:0], win_valid.
  - Implementation: a masked search (req & ~((1<<ptr)-1)) with fallback to the unmasked search.

Test Plan:
- Reset, then req=8'h00 -> gnt=00, gnt_valid=0, gnt_idx=0 for 10 cycles; assert rst_n low mid-grant -> outputs clear without waiting for a clock edge.
- req=8'h01 held 3 cycles then dropped -> gnt=01 from cycle 1 to cycle 3, gnt_idx=0, release, ptr=1; IDLE afterwards.
- req=8'hFF held continuously, each holder dropping after 2 cycles and re-raising -> grant order 0,1,2,...,7,0 with no idle cycles between grants.
- ptr=6, req=8'h41 (bits 0 and 6) -> grant 6 first; after release, grant 0 (wrap) in the next cycle.
- MAX_HOLD=16, req=8'h08 held 40 cycles -> gnt=08 for 16 cycles, then timeout pulse, then re-grant to 3; a second timeout pulse follows at cycle 32+.
- Grant active on 2 with req=8'h24; drop en for 1 cycle -> gnt clears, timeout=0; en high again -> grant 5 (ptr=3).
